// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the memory-stage request port and the data RAM.
// Define LSU_MISALIGN_EN to split misaligned half/word accesses into little-endian byte beats.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_we,
  output logic [1:0]        ram_mem_ctrl,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] size_mask;
  logic              req_mis;
  logic              access_done;

  assign req_mis = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  always_comb begin
    size_mask = '1;
    case (size_q)
      SZ_BYTE: size_mask = DATA_W'(32'h0000_00FF);
      SZ_HALF: size_mask = DATA_W'(32'h0000_FFFF);
      default: size_mask = '1;
    endcase
  end

`ifdef LSU_MISALIGN_EN
  logic       mis_q, mis_d;
  logic [1:0] beat_q, beat_d;
  logic [1:0] last_beat;

  assign last_beat   = (size_q == SZ_HALF) ? 2'd1 : 2'd3;
  assign access_done = !mis_q || (beat_q == last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q  <= 1'b0;
      beat_q <= 2'd0;
    end else begin
      mis_q  <= mis_d;
      beat_q <= beat_d;
    end
  end
`else
  assign access_done = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    ram_we       = 1'b0;
    ram_mem_ctrl = SZ_BYTE;
    ram_address  = '0;
    ram_data_in  = '0;
`ifdef LSU_MISALIGN_EN
    mis_d        = mis_q;
    beat_d       = beat_q;
`endif
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          acc_d   = '0;
`ifdef LSU_MISALIGN_EN
          err_d   = (req_size == SZ_RSVD);
          mis_d   = req_mis;
          beat_d  = 2'd0;
`else
          err_d   = (req_size == SZ_RSVD) || req_mis;
`endif
          state_d = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        ram_we = we_q;
`ifdef LSU_MISALIGN_EN
        if (mis_q) begin
          // Misaligned beats move one byte each, lowest address first.
          ram_mem_ctrl = SZ_BYTE;
          ram_address  = addr_q + ADDR_W'(beat_q);
          ram_data_in  = DATA_W'(wdata_q[{beat_q, 3'b000} +: 8]);
          if (!we_q) acc_d[{beat_q, 3'b000} +: 8] = ram_data_out[7:0];
          beat_d = beat_q + 2'd1;
        end else
`endif
        begin
          ram_mem_ctrl = size_q;
          ram_address  = addr_q;
          ram_data_in  = wdata_q;
          if (!we_q) acc_d = ram_data_out & size_mask;
        end
        if (access_done) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = '0;
    if ((state_q == RESP) && !we_q && !err_q) begin
      case (size_q)
        SZ_BYTE: rsp_rdata = {{(DATA_W-8){acc_q[7] & ~uns_q}}, acc_q[7:0]};
        SZ_HALF: rsp_rdata = {{(DATA_W-16){acc_q[15] & ~uns_q}}, acc_q[15:0]};
        default: rsp_rdata = acc_q;
      endcase
    end
  end

endmodule
